// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and constants for the pipeline stall/flush controller
// Purpose: exception cause encoding, stall vector bit indices, stall patterns, default
//          exception vector, and the stall-request priority encoder.
// Ports:   none (package)
package pipeline_ctrl_pkg;

   typedef enum logic [4:0] {
      EXCP_INT     = 5'd0,
      EXCP_ADEL    = 5'd4,
      EXCP_ADES    = 5'd5,
      EXCP_SYSCALL = 5'd8,
      EXCP_BREAK   = 5'd9,
      EXCP_RI      = 5'd10,
      EXCP_OV      = 5'd12,
      EXCP_TRAP    = 5'd13,
      EXCP_ERET    = 5'd14
   } excp_t;

   // Bit positions inside the 6-bit stall vector.
   localparam int STALL_PC  = 0;
   localparam int STALL_IF  = 1;
   localparam int STALL_ID  = 2;
   localparam int STALL_EX  = 3;
   localparam int STALL_MEM = 4;
   localparam int STALL_WB  = 5;

   // Each pattern holds every stage up to the requester and lets the next
   // register take a bubble.
   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_IFQ  = 6'b000011;
   localparam logic [5:0] STALL_IDQ  = 6'b000111;
   localparam logic [5:0] STALL_EXQ  = 6'b001111;
   localparam logic [5:0] STALL_MEMQ = 6'b011111;

   localparam logic [31:0] DEFAULT_EXCP_VECTOR = 32'h0000_0020;

   // Highest-stage requester wins outright.
   function automatic logic [5:0] stall_pattern(input logic req_if, input logic req_id,
                                                input logic req_ex, input logic req_mem);
      if (req_mem)     return STALL_MEMQ;
      else if (req_ex) return STALL_EXQ;
      else if (req_id) return STALL_IDQ;
      else if (req_if) return STALL_IFQ;
      else             return STALL_NONE;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - stall/flush bus between pipeline stages and the controller
// Purpose: bundles per-stage stall requests, the committed exception and the
//          resulting stall/flush/redirect outputs.
// Ports:   none; modport master = pipeline side, modport slave = controller side
//   stallreq_if/id/ex/mem  per-stage hold requests
//   excp_valid/excp_type   exception or ERET committed in MEM
//   epc_i                  current EPC for ERET
//   stall[5:0]             1 = hold stage (pc, if, id, ex, mem, wb)
//   flush, new_pc          clear pipeline and redirect
interface pipeline_ctrl_if;
   import pipeline_ctrl_pkg::*;

   logic        stallreq_if;
   logic        stallreq_id;
   logic        stallreq_ex;
   logic        stallreq_mem;
   logic        excp_valid;
   excp_t       excp_type;
   logic [31:0] epc_i;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;

   modport master (
      output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
      output excp_valid, excp_type, epc_i,
      input  stall, flush, new_pc
   );

   modport slave (
      input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
      input  excp_valid, excp_type, epc_i,
      output stall, flush, new_pc
   );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// rtl/pipeline_ctrl_sat_counter.sv - saturating up-counter with synchronous clear
// Purpose: counts cycles where inc=1, sticks at all-ones, clr wins over inc.
// Ports:
//   clk    in  1      clock
//   rst    in  1      asynchronous active-high reset
//   inc    in  1      count this cycle
//   clr    in  1      synchronous clear
//   count  out CNT_W  current count
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - central stall/flush controller for the 5-stage pipeline
// Purpose: merges stage stall requests into the stall vector, sequences exception
//          and ERET redirects (flush + new_pc) and counts stalled cycles.
// Ports:
//   clk           in   1      clock
//   rst           in   1      asynchronous active-high reset
//   bus           slave      pipeline_ctrl_if (requests in; stall/flush/new_pc out)
//   clr_perf      in   1      synchronous clear of stall_cycles
//   stall_cycles  out  CNT_W  saturating count of cycles with stall[0]=1
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter logic [31:0] EXCP_VECTOR = DEFAULT_EXCP_VECTOR,
   parameter int          FLUSH_HOLD  = 1,
   parameter int          CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   pipeline_ctrl_if.slave   bus,
   input  logic             clr_perf,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int HOLD_W = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [5:0]          stall_c;
   logic                flush_c;
   logic [31:0]         new_pc_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      stall_c  = STALL_NONE;
      flush_c  = 1'b0;
      new_pc_c = '0;
      // Outputs are forced quiet while reset is held, whatever the inputs do.
      if (!rst) begin
         case (state_q)
            RUN: begin
               // A data-bus wait defers the exception: MEM keeps excp_valid
               // asserted, so it fires the first cycle the wait drops.
               if (bus.excp_valid && !bus.stallreq_mem) begin
                  flush_c  = 1'b1;
                  new_pc_c = (bus.excp_type == EXCP_ERET) ? bus.epc_i : EXCP_VECTOR;
                  state_d  = HOLD;
                  hold_d   = HOLD_W'(FLUSH_HOLD - 1);
               end else begin
                  stall_c = stall_pattern(bus.stallreq_if, bus.stallreq_id,
                                          bus.stallreq_ex, bus.stallreq_mem);
               end
            end
            HOLD: begin
               // The flushed MEM stage may still show excp_valid; ignore it here.
               stall_c = stall_pattern(bus.stallreq_if, bus.stallreq_id,
                                       bus.stallreq_ex, bus.stallreq_mem);
               if (hold_q == '0) begin
                  state_d = RUN;
               end else begin
                  hold_d = hold_q - HOLD_W'(1);
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   assign bus.stall  = stall_c;
   assign bus.flush  = flush_c;
   assign bus.new_pc = new_pc_c;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_c[STALL_PC]),
      .clr   (clr_perf),
      .count (stall_cycles)
   );

endmodule
